// File: rtl/loop_index_regs.sv
// Loop-state register bank: ROW/COL sweep indices, CURR pointer and SUM accumulator.
// Optional build macro SUM_SAT_EN: saturate SUM on overflow instead of wrapping.
module loop_index_regs #(
    parameter int IDX_W = 8,
    parameter int SUM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_ROW,
    input  logic             rst_COL,
    input  logic             rst_CURR,
    input  logic             rst_SUM,
    input  logic             inc_ROW,
    input  logic             inc_COL,
    input  logic             inc_CURR,
    input  logic             acc_en,
    input  logic [SUM_W-1:0] acc_in,
    input  logic [IDX_W-1:0] row_lim,
    input  logic [IDX_W-1:0] col_lim,
    output logic [IDX_W-1:0] ROW,
    output logic [IDX_W-1:0] COL,
    output logic [IDX_W-1:0] CURR,
    output logic [SUM_W-1:0] SUM,
    output logic             col_end,
    output logic             row_end,
    output logic             done,
    output logic             sum_ovf
);

    logic             col_carry;
    logic             row_adv;
    logic [SUM_W:0]   sum_ext;
    logic [SUM_W-1:0] sum_next;

    assign col_end = (COL == col_lim);
    assign row_end = (ROW == row_lim);

    // A COL clear in the same cycle suppresses the carry into ROW.
    assign col_carry = inc_COL && col_end && !rst_COL;
    assign row_adv   = inc_ROW || col_carry;

    assign sum_ext = {1'b0, SUM} + {1'b0, acc_in};
`ifdef SUM_SAT_EN
    assign sum_next = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
`else
    assign sum_next = sum_ext[SUM_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ROW     <= '0;
            COL     <= '0;
            CURR    <= '0;
            SUM     <= '0;
            done    <= 1'b0;
            sum_ovf <= 1'b0;
        end else begin
            if (rst_COL)
                COL <= '0;
            else if (inc_COL)
                COL <= col_end ? '0 : COL + 1'b1;

            if (rst_ROW)
                ROW <= '0;
            else if (row_adv)
                ROW <= row_end ? '0 : ROW + 1'b1;

            // Only the sweep carry at the last row completes the loop.
            if (rst_ROW)
                done <= 1'b0;
            else if (col_carry && row_end)
                done <= 1'b1;

            if (rst_CURR)
                CURR <= '0;
            else if (inc_CURR)
                CURR <= CURR + 1'b1;

            if (rst_SUM) begin
                SUM     <= '0;
                sum_ovf <= 1'b0;
            end else if (acc_en) begin
                SUM <= sum_next;
                if (sum_ext[SUM_W])
                    sum_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_loop_index_regs.sv
// Directed self-checking bench for loop_index_regs (default IDX_W=8, SUM_W=16).
// Honours SUM_SAT_EN when selecting accumulator expectations.
module tb_loop_index_regs;

    logic        clk = 1'b0;
    logic        rst, rst_ROW, rst_COL, rst_CURR, rst_SUM;
    logic        inc_ROW, inc_COL, inc_CURR, acc_en;
    logic [15:0] acc_in;
    logic [7:0]  row_lim, col_lim;
    logic [7:0]  ROW, COL, CURR;
    logic [15:0] SUM;
    logic        col_end, row_end, done, sum_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    loop_index_regs dut (
        .clk(clk), .rst(rst),
        .rst_ROW(rst_ROW), .rst_COL(rst_COL), .rst_CURR(rst_CURR), .rst_SUM(rst_SUM),
        .inc_ROW(inc_ROW), .inc_COL(inc_COL), .inc_CURR(inc_CURR),
        .acc_en(acc_en), .acc_in(acc_in),
        .row_lim(row_lim), .col_lim(col_lim),
        .ROW(ROW), .COL(COL), .CURR(CURR), .SUM(SUM),
        .col_end(col_end), .row_end(row_end), .done(done), .sum_ovf(sum_ovf)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        rst = 0; rst_ROW = 0; rst_COL = 0; rst_CURR = 0; rst_SUM = 0;
        inc_ROW = 0; inc_COL = 0; inc_CURR = 0; acc_en = 0; acc_in = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        row_lim = 8'd5; col_lim = 8'd0;
        rst = 1; rst_ROW = 1; rst_COL = 1; rst_CURR = 1; rst_SUM = 1;
        inc_ROW = 1; inc_COL = 1; inc_CURR = 1; acc_en = 1; acc_in = 16'h1234;
        step();
        idle();
        n_checks++;
        if ({ROW, COL, CURR, SUM, done, sum_ovf} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_state: ROW=%0d COL=%0d CURR=%0d SUM=%h done=%b ovf=%b, required all 0",
                     ROW, COL, CURR, SUM, done, sum_ovf);
        end
        n_checks++;
        if ({col_end, row_end} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_ends: col_end,row_end=%b, required 10", {col_end, row_end});
        end
    endtask

    task automatic test_full_sweep();
        logic [7:0] exp_col, exp_row;
        logic       exp_done;
        row_lim = 8'd2; col_lim = 8'd3;
        do_reset();
        inc_COL = 1;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_col  = 8'(k % 4);
            exp_row  = 8'((k / 4) % 3);
            exp_done = (k >= 12);
            n_checks++;
            if ({ROW, COL, done, col_end} !== {exp_row, exp_col, exp_done, (exp_col == 8'd3)}) begin
                n_fail++;
                $display("FAIL sweep_k%0d: ROW=%0d COL=%0d done=%b col_end=%b, required ROW=%0d COL=%0d done=%b col_end=%b",
                         k, ROW, COL, done, col_end, exp_row, exp_col, exp_done, (exp_col == 8'd3));
            end
        end
        inc_COL = 0;
        step(2);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_done_sticky: done=%b, required 1", done);
        end
    endtask

    task automatic test_clear_priority();
        row_lim = 8'd2; col_lim = 8'd3;
        do_reset();
        inc_COL = 1;
        step(7);
        n_checks++;
        if ({ROW, COL} !== {8'd1, 8'd3}) begin
            n_fail++;
            $display("FAIL prio_setup: ROW=%0d COL=%0d, required 1 3", ROW, COL);
        end
        inc_ROW = 1; rst_ROW = 1;
        step();
        n_checks++;
        if ({ROW, COL, done} !== {8'd0, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_rst_row: ROW=%0d COL=%0d done=%b, required 0 0 0", ROW, COL, done);
        end
        inc_ROW = 0; rst_ROW = 0;
        step(7);
        inc_ROW = 1;
        step();
        n_checks++;
        if ({ROW, COL} !== {8'd2, 8'd0}) begin
            n_fail++;
            $display("FAIL prio_plus_one: ROW=%0d COL=%0d, required 2 0", ROW, COL);
        end
        inc_COL = 0;
        step();
        n_checks++;
        if ({ROW, done} !== {8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL inc_row_wrap: ROW=%0d done=%b, required 0 0", ROW, done);
        end
        inc_ROW = 0; inc_COL = 1;
        step(3);
        rst_COL = 1;
        step();
        n_checks++;
        if ({ROW, COL} !== {8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL rst_col_no_carry: ROW=%0d COL=%0d, required 0 0", ROW, COL);
        end
        idle();
    endtask

    task automatic test_limit_zero();
        row_lim = 8'd0; col_lim = 8'd0;
        do_reset();
        inc_COL = 1;
        step();
        inc_COL = 0;
        n_checks++;
        if ({ROW, COL, done} !== {8'd0, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL limit_zero: ROW=%0d COL=%0d done=%b, required 0 0 1", ROW, COL, done);
        end
        // Mid-operation reset with everything requested still clears all state.
        acc_en = 1; acc_in = 16'h0003; inc_CURR = 1;
        step();
        rst = 1; inc_COL = 1; inc_ROW = 1;
        step();
        idle();
        n_checks++;
        if ({ROW, COL, CURR, SUM, done, sum_ovf} !== 42'd0) begin
            n_fail++;
            $display("FAIL mid_reset: ROW=%0d COL=%0d CURR=%0d SUM=%h done=%b ovf=%b, required all 0",
                     ROW, COL, CURR, SUM, done, sum_ovf);
        end
    endtask

    task automatic test_accumulator();
        logic [15:0] exp_sum;
`ifdef SUM_SAT_EN
        exp_sum = 16'hFFFF;
`else
        exp_sum = 16'h0010;
`endif
        do_reset();
        acc_en = 1; acc_in = 16'hFFF0;
        step();
        n_checks++;
        if ({SUM, sum_ovf} !== {16'hFFF0, 1'b0}) begin
            n_fail++;
            $display("FAIL acc_load: SUM=%h ovf=%b, required fff0 0", SUM, sum_ovf);
        end
        acc_in = 16'h0020;
        step();
        acc_en = 0;
        n_checks++;
        if ({SUM, sum_ovf} !== {exp_sum, 1'b1}) begin
            n_fail++;
            $display("FAIL acc_overflow: SUM=%h ovf=%b, required %h 1", SUM, sum_ovf, exp_sum);
        end
        step();
        n_checks++;
        if (sum_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL acc_ovf_sticky: ovf=%b, required 1", sum_ovf);
        end
        rst_SUM = 1; acc_en = 1;
        step();
        idle();
        n_checks++;
        if ({SUM, sum_ovf} !== {16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL acc_clear: SUM=%h ovf=%b, required 0000 0", SUM, sum_ovf);
        end
    endtask

    task automatic test_strobes();
        logic [7:0] exp_curr [5] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2};
        row_lim = 8'd4; col_lim = 8'd9;
        do_reset();
        acc_en = 1; acc_in = 16'h0007; inc_CURR = 1;
        step(5);
        acc_en = 0;
        inc_CURR = 0; inc_COL = 1; inc_ROW = 1;
        step(2);
        inc_COL = 0; inc_ROW = 0;
        n_checks++;
        if ({CURR, ROW, COL, SUM} !== {8'd5, 8'd2, 8'd2, 16'd35}) begin
            n_fail++;
            $display("FAIL strobe_setup: CURR=%0d ROW=%0d COL=%0d SUM=%0d, required 5 2 2 35", CURR, ROW, COL, SUM);
        end
        inc_CURR = 1; rst_CURR = 1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) rst_CURR = 0;
            step();
            n_checks++;
            if (CURR !== exp_curr[i]) begin
                n_fail++;
                $display("FAIL strobe_curr_%0d: CURR=%0d, required %0d", i, CURR, exp_curr[i]);
            end
        end
        inc_CURR = 0;
        n_checks++;
        if ({ROW, COL, SUM} !== {8'd2, 8'd2, 16'd35}) begin
            n_fail++;
            $display("FAIL strobe_others: ROW=%0d COL=%0d SUM=%0d, required 2 2 35", ROW, COL, SUM);
        end
    endtask

    task automatic test_curr_wrap();
        row_lim = 8'd3; col_lim = 8'd3;
        do_reset();
        inc_CURR = 1;
        step(255);
        n_checks++;
        if (CURR !== 8'd255) begin
            n_fail++;
            $display("FAIL curr_at_max: CURR=%0d, required 255", CURR);
        end
        step();
        inc_CURR = 0;
        n_checks++;
        if ({CURR, ROW, COL, SUM, done, sum_ovf, col_end, row_end} !== {8'd0, 8'd0, 8'd0, 16'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL curr_wrap: CURR=%0d ROW=%0d COL=%0d SUM=%h flags=%b, required 0 0 0 0000 0000",
                     CURR, ROW, COL, SUM, {done, sum_ovf, col_end, row_end});
        end
    endtask

    initial begin
        idle();
        row_lim = '0; col_lim = '0;
        test_reset();
        test_full_sweep();
        test_clear_priority();
        test_limit_zero();
        test_accumulator();
        test_strobes();
        test_curr_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/loop_index_regs.md
# loop_index_regs

Register bank holding the CCSS processor's loop state: the ROW and COL indices, the CURR pointer and the SUM accumulator. It sits directly downstream of the reset decoder and takes that decoder's one-hot `rst_ROW`/`rst_COL`/`rst_CURR`/`rst_SUM` strobes as per-register synchronous clears. Increment and accumulate enables come from the control unit. Its index, end-of-loop and done outputs feed back to the control unit and the address generator.

## Interface
- `IDX_W`, default 8: width of ROW, COL, CURR and of the limit inputs.
- `SUM_W`, default 16: width of SUM and `acc_in`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: global reset, synchronous, active-high; clears all state.
- `rst_ROW` in 1: synchronous clear of ROW, also clears `done`.
- `rst_COL` in 1: synchronous clear of COL.
- `rst_CURR` in 1: synchronous clear of CURR.
- `rst_SUM` in 1: synchronous clear of SUM, also clears `sum_ovf`.
- `inc_ROW` in 1: ROW increment request.
- `inc_COL` in 1: COL increment request, with carry into ROW.
- `inc_CURR` in 1: CURR increment request, free-running wrap at 2^IDX_W.
- `acc_en` in 1: accumulate request, SUM <= SUM + `acc_in`.
- `acc_in` in SUM_W: unsigned accumulate operand.
- `row_lim` in IDX_W: last valid ROW value. Must be held stable while counting.
- `col_lim` in IDX_W: last valid COL value. Must be held stable while counting.
- `ROW` out IDX_W: registered row index.
- `COL` out IDX_W: registered column index.
- `CURR` out IDX_W: registered current pointer.
- `SUM` out SUM_W: registered accumulator.
- `col_end` out 1: combinational, (COL == `col_lim`).
- `row_end` out 1: combinational, (ROW == `row_lim`).
- `done` out 1: registered sticky flag, set when the full ROW×COL sweep completes.
- `sum_ovf` out 1: registered sticky flag, set on accumulator overflow.

## Operation
- **Priority per register, highest first:**
  1. `rst`
  2. that register's `rst_*` strobe
  3. increment/accumulate
  4. hold
- **COL:** on `inc_COL`, if `col_end` then COL <= 0 and a carry is raised; otherwise COL <= COL+1.
- **ROW:** advances by exactly 1 when `inc_ROW` OR the COL carry is true. Both together still give +1, never +2.
  - If ROW would advance while `row_end`, ROW <= 0.
- **done:** set when the COL carry occurs while `row_end` is true (last element of the sweep consumed).
  - Stays set until `rst` or `rst_ROW`.
  - `inc_ROW` alone at `row_end` wraps ROW but does not set `done`.
- **Clear vs. carry:** `rst_ROW` in the same cycle as a COL carry clears ROW, and `done` stays 0. `rst_COL` together with `inc_COL` gives COL = 0 and no carry.
- **CURR:** wraps from 2^IDX_W−1 to 0. There is no flag.
- **SUM:** `acc_en` computes a SUM_W+1-bit sum. Carry-out sets `sum_ovf`. The SUM result depends on the configuration (see Configuration).
- **Strobe width:** `rst_*` strobes are level-sensitive. A strobe held N cycles keeps its register at 0 for N cycles.
- **Limit of 0:** `col_lim` = 0 makes every `inc_COL` a carry. `row_lim` = `col_lim` = 0 sets `done` on the first `inc_COL`.

## Timing
- Reset values: ROW = COL = CURR = 0, SUM = 0, `done` = 0, `sum_ovf` = 0. `col_end` and `row_end` are then (0 == limit).
- **Latency:** any enable or strobe sampled at edge k is visible on the outputs after edge k.
  - `col_end`/`row_end` follow in the same cycle through combinational logic.
  - `done` is set at the same edge as the wrap that causes it.
- **No handshake:** requests act every cycle they are high. No back-pressure and no busy state.
- **Mid-operation reset:** `rst` asserted mid-sweep zeroes everything at the next edge. All enables that cycle are ignored.

## Configuration
- Macro: `SUM_SAT_EN`.
  - **Defined:** on overflow, SUM <= 2^SUM_W−1 (saturate) and `sum_ovf` is set. Further `acc_en` holds SUM at maximum.
  - **Undefined:** SUM wraps modulo 2^SUM_W and `sum_ovf` is still set on carry-out.
- The macro changes nothing else.

## Test plan
- **Reset:** `rst` high for 1 cycle with all enables high → the next cycle shows all outputs 0 and `col_end` = 1 if `col_lim` = 0.
- **Full sweep:** `row_lim` = 2, `col_lim` = 3, `inc_COL` held for 12 cycles → COL sequence 0,1,2,3,0,…; ROW 0→1→2→0; `done` rises exactly at edge 12 and stays high.
- **Clear priority:** with COL = 3 = `col_lim` and ROW = 1, assert `inc_COL`, `inc_ROW` and `rst_ROW` together → COL = 0, ROW = 0, `done` = 0. Repeat without `rst_ROW` → ROW = 2, not 3.
- **Accumulator, SUM_W = 16:** SUM = 0xFFF0, `acc_in` = 0x0020.
  - With `SUM_SAT_EN`: SUM = 0xFFFF and `sum_ovf` = 1.
  - Without it: SUM = 0x0010 and `sum_ovf` = 1.
  - Then `rst_SUM` → SUM = 0 and `sum_ovf` = 0.
- **Decoder strobes:** drive `rst_CURR` for 3 cycles while `inc_CURR` is high from CURR = 5 → CURR = 0,0,0, then 1,2 once the strobe drops. ROW, COL and SUM are unaffected.
- **CURR wrap:** CURR = 255 (IDX_W = 8) + `inc_CURR` → CURR = 0, with no other output change.
